channel_add_seq: RTL
====================

// Module: channel_add_seq
// PURPOSE
//  Sequencer for the 8-channel accumulator (channelAdd) in the GEMM output path.
//  Accepts a start command with a pass count and clears the accumulators.
//  Feeds num_pass x NUM_CH partial sums into channelAdd in channel order.
//  Then streams the NUM_CH final sums to the downstream consumer with valid/ready, and pulses done.
// PARAMETERS
//  DATA_W  32  width of partial sums and accumulator results (two's complement)
//  NUM_CH  8   accumulator channels; must match channelAdd
//  PASS_W  8   width of num_pass; maximum 2^PASS_W-1 passes
// PORTS
//  clk        in   1              rising-edge clock
//  reset      in   1              synchronous, active-high reset
//  start      in   1              command strobe; sampled only in IDLE
//  num_pass   in   PASS_W         passes to accumulate; latched when start is taken
//  busy       out  1              high in INIT, ACCUM, DRAIN and OUT
//  done       out  1              one-cycle pulse in DONE
//  psum_valid in   1              upstream partial sum valid
//  psum_data  in   DATA_W         upstream partial sum
//  psum_ready out  1              high only in ACCUM
//  add_valid  out  1              to channelAdd ChannelAddData_Valid
//  add_data   out  DATA_W         to channelAdd dataIn
//  add_init   out  1              to channelAdd init; clears the sums and the channel pointer
//  acc_in     in   NUM_CH*DATA_W  {dataOut_7..dataOut_0}; channel c is acc_in[c*DATA_W +: DATA_W]
//  out_valid  out  1              final sum valid (OUT state)
//  out_ready  in   1              downstream accept
//  out_ch     out  $clog2(NUM_CH) channel index of out_data
//  out_data   out  DATA_W         acc_in slice selected by out_ch
//  out_last   out  1              out_valid && out_ch==NUM_CH-1
// BEHAVIOUR
//  Reset:
//   - state=IDLE; every output 0; counters 0.
//   - Reset mid-operation aborts immediately and issues no add_init.
//  FSM states: IDLE -> INIT -> ACCUM -> DRAIN -> OUT -> DONE -> IDLE.
//  IDLE:
//   - On start: latch num_pass and go to INIT.
//  INIT:
//   - Exactly 1 cycle with add_init=1.
//   - Next state is ACCUM, or DONE if num_pass==0 (then no beats and no out_valid).
//  ACCUM:
//   - Beat accepted when psum_valid && psum_ready.
//   - add_valid/add_data are registered copies of the beat: 1-cycle latency, 0 when no beat.
//   - ch_cnt wraps at NUM_CH-1; on wrap pass_cnt increments.
//   - After beat num_pass*NUM_CH is accepted: psum_ready drops in the same cycle's next state; go to DRAIN.
//  DRAIN:
//   - Fixed 2 cycles: registered add_valid, then channelAdd register update. add_valid=0 after the first.
//  OUT:
//   - out_valid=1; out_ch starts at 0.
//   - out_data is combinational from acc_in and stays stable while out_ready=0.
//   - On out_valid && out_ready: out_ch++. On the last handshake go to DONE.
//  DONE:
//   - done=1 and busy=0 for 1 cycle, then IDLE.
//  Simultaneous/ignored events:
//   - start outside IDLE is ignored, including in DONE.
//   - psum_valid outside ACCUM is ignored (ready=0).
//  Arithmetic:
//   - No arithmetic on data. Counters are unsigned.
//   - Comparison pass_cnt==num_pass_q-1 && ch_cnt==NUM_CH-1 marks the final beat.
// STRUCTURE
//  - Package channel_add_pkg: state enum (IDLE, INIT, ACCUM, DRAIN, OUT, DONE), default DATA_W/NUM_CH.
//  - One sub-module beat_counter: ch_cnt/pass_cnt with clear, enable, wrap and last flags.
//  - FSM and output mux stay in the top.
// TESTING (bench uses a behavioural channelAdd model: init clears, valid adds to ptr channel)
//  1. num_pass=2, beats 1..8 then -1..-8, out_ready=1
//     -> add_init 1 cycle; out_data 0 on out_ch 0..7; out_last on ch 7; done once.
//  2. num_pass=1, beats 1..8 with psum_valid low every other cycle
//     -> add_valid only 1 cycle after each accepted beat; outputs 1..8.
//  3. Case 1 values, out_ready toggled 1-0-1
//     -> out_data/out_ch held while stalled; each channel delivered exactly once.
//  4. num_pass=0
//     -> INIT then DONE; done 2 cycles after start; never psum_ready or out_valid.
//  5. reset=1 after 3 accepted beats, then new start with num_pass=1, beats 10..17
//     -> all outputs 0 during reset; results 10..17 with no stale sums.
//  6. start pulsed during ACCUM and in DONE
//     -> ignored; exactly one done per accepted start; num_pass unchanged.

Source files
------------

// File: rtl/channel_add_seq_pkg.sv
// Shared types and defaults for the channelAdd sequencer.
package channel_add_pkg;

   localparam int DEF_DATA_W = 32;
   localparam int DEF_NUM_CH = 8;
   localparam int DEF_PASS_W = 8;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      INIT  = 3'd1,
      ACCUM = 3'd2,
      DRAIN = 3'd3,
      OUT   = 3'd4,
      DONE  = 3'd5
   } state_t;

   // Width of a channel index; a single channel still needs one bit.
   function automatic int ch_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/channel_add_seq_if.sv
// Command, partial-sum, channelAdd and result-stream signals of the sequencer.
interface channel_add_seq_if #(
   parameter int DATA_W = channel_add_pkg::DEF_DATA_W,
   parameter int NUM_CH = channel_add_pkg::DEF_NUM_CH,
   parameter int PASS_W = channel_add_pkg::DEF_PASS_W
);
   import channel_add_pkg::*;

   localparam int CH_W = ch_width(NUM_CH);

   logic                     start;
   logic [PASS_W-1:0]        num_pass;
   logic                     busy;
   logic                     done;
   logic                     psum_valid;
   logic [DATA_W-1:0]        psum_data;
   logic                     psum_ready;
   logic                     add_valid;
   logic [DATA_W-1:0]        add_data;
   logic                     add_init;
   logic [NUM_CH*DATA_W-1:0] acc_in;
   logic                     out_valid;
   logic                     out_ready;
   logic [CH_W-1:0]          out_ch;
   logic [DATA_W-1:0]        out_data;
   logic                     out_last;

   // Sequencer side
   modport master (
      input  start, num_pass, psum_valid, psum_data, acc_in, out_ready,
      output busy, done, psum_ready, add_valid, add_data, add_init,
             out_valid, out_ch, out_data, out_last
   );

   // Environment side (command source, upstream, channelAdd, consumer)
   modport slave (
      output start, num_pass, psum_valid, psum_data, acc_in, out_ready,
      input  busy, done, psum_ready, add_valid, add_data, add_init,
             out_valid, out_ch, out_data, out_last
   );

endinterface

// File: rtl/channel_add_seq_beat_counter.sv
// Channel/pass counter for accepted partial sums; flags the final beat.
module beat_counter
   import channel_add_pkg::*;
#(
   parameter int NUM_CH = DEF_NUM_CH,
   parameter int PASS_W = DEF_PASS_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clear,
   input  logic              en,
   input  logic [PASS_W-1:0] num_pass,
   output logic              last
);
   localparam int CH_W = ch_width(NUM_CH);

   logic [CH_W-1:0]   ch_cnt_reg;
   logic [PASS_W-1:0] pass_cnt_reg;
   logic              wrap;

   // The channel counter wraps after the highest channel, closing one pass.
   assign wrap = (ch_cnt_reg == CH_W'(NUM_CH - 1));
   assign last = wrap && (pass_cnt_reg == num_pass - PASS_W'(1));

   // Advance one channel per accepted beat; pass count steps on each wrap.
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         ch_cnt_reg   <= '0;
         pass_cnt_reg <= '0;
      end else if (en) begin
         if (wrap) begin
            ch_cnt_reg   <= '0;
            pass_cnt_reg <= pass_cnt_reg + PASS_W'(1);
         end else begin
            ch_cnt_reg <= ch_cnt_reg + CH_W'(1);
         end
      end
   end

endmodule

// File: rtl/channel_add_seq.sv
// Sequencer: clears channelAdd, feeds num_pass x NUM_CH partial sums,
// waits for the accumulator to settle, then streams the NUM_CH results.
module channel_add_seq
   import channel_add_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int NUM_CH = DEF_NUM_CH,
   parameter int PASS_W = DEF_PASS_W
) (
   input  logic               clk,
   input  logic               reset,
   channel_add_seq_if.master  bus
);
   localparam int CH_W = ch_width(NUM_CH);

   state_t            state_reg, state_next;
   logic [PASS_W-1:0] num_pass_reg;
   logic              add_valid_reg;
   logic [DATA_W-1:0] add_data_reg;
   logic              drain_reg;
   logic [CH_W-1:0]   out_ch_reg;

   logic              beat;
   logic              last_beat;
   logic              ch_top;
   logic              busy_c, done_c, ready_c, init_c, out_valid_c;
   logic [DATA_W-1:0] acc_slice [NUM_CH];

   assign beat   = (state_reg == ACCUM) && bus.psum_valid;
   assign ch_top = (out_ch_reg == CH_W'(NUM_CH - 1));

   beat_counter #(
      .NUM_CH (NUM_CH),
      .PASS_W (PASS_W)
   ) u_beat_counter (
      .clk      (clk),
      .reset    (reset),
      .clear    (state_reg == INIT),
      .en       (beat),
      .num_pass (num_pass_reg),
      .last     (last_beat)
   );

   // Split the flat accumulator bus into per-channel words.
   genvar gi;
   generate
      for (gi = 0; gi < NUM_CH; gi++) begin : g_slice
         assign acc_slice[gi] = bus.acc_in[gi*DATA_W +: DATA_W];
      end
   endgenerate

   // State register; reset aborts any operation without clearing channelAdd.
   always_ff @(posedge clk) begin
      if (reset) state_reg <= IDLE;
      else       state_reg <= state_next;
   end

   // Next state and state-decoded outputs.
   always_comb begin
      state_next  = state_reg;
      busy_c      = 1'b0;
      done_c      = 1'b0;
      ready_c     = 1'b0;
      init_c      = 1'b0;
      out_valid_c = 1'b0;
      case (state_reg)
         IDLE: begin
            if (bus.start) state_next = INIT;
         end
         INIT: begin
            busy_c     = 1'b1;
            init_c     = 1'b1;
            state_next = (num_pass_reg == '0) ? DONE : ACCUM;
         end
         ACCUM: begin
            busy_c  = 1'b1;
            ready_c = 1'b1;
            if (bus.psum_valid && last_beat) state_next = DRAIN;
         end
         DRAIN: begin
            // First cycle carries the final add_valid, second lets the sums settle.
            busy_c = 1'b1;
            if (drain_reg) state_next = OUT;
         end
         OUT: begin
            busy_c      = 1'b1;
            out_valid_c = 1'b1;
            if (bus.out_ready && ch_top) state_next = DONE;
         end
         DONE: begin
            done_c     = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Command latch, registered beat copy to channelAdd, drain and output counters.
   always_ff @(posedge clk) begin
      if (reset) begin
         num_pass_reg  <= '0;
         add_valid_reg <= 1'b0;
         add_data_reg  <= '0;
         drain_reg     <= 1'b0;
         out_ch_reg    <= '0;
      end else begin
         if (state_reg == IDLE && bus.start) num_pass_reg <= bus.num_pass;
         add_valid_reg <= beat;
         add_data_reg  <= beat ? bus.psum_data : '0;
         drain_reg     <= (state_reg == DRAIN) && !drain_reg;
         if (state_reg != OUT)  out_ch_reg <= '0;
         else if (bus.out_ready) out_ch_reg <= ch_top ? '0 : out_ch_reg + CH_W'(1);
      end
   end

   assign bus.busy       = busy_c;
   assign bus.done       = done_c;
   assign bus.psum_ready = ready_c;
   assign bus.add_init   = init_c;
   assign bus.add_valid  = add_valid_reg;
   assign bus.add_data   = add_data_reg;
   assign bus.out_valid  = out_valid_c;
   assign bus.out_ch     = out_ch_reg;
   assign bus.out_data   = out_valid_c ? acc_slice[out_ch_reg] : '0;
   assign bus.out_last   = out_valid_c && ch_top;

endmodule
